output_reg_arbiter: RTL and testbench
=====================================

# output_reg_arbiter

Round-robin arbiter and write sequencer for the 256-bit output register. Up to NREQ requesters, such as the matrix ALU, the memory load path and the host, compete to publish a result. The block grants one requester at a time, drives the output register's write_data / data_to_write inputs with a single-cycle write pulse, then holds off further writes until the downstream consumer acknowledges the current value. It sits directly in front of output_reg and owns that register's write port exclusively.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 256, data width; must match output_reg
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- req  input  NREQ  per-requester write request, level; held until granted
- req_data  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]; stable while req[i]=1
- gnt  output  NREQ  one-hot, one-cycle pulse to the requester whose data is being written
- write_data  output  1  write strobe to output_reg, one cycle per accepted request
- data_to_write  output  WIDTH  registered data to output_reg; holds last written value
- out_valid  output  1  output register holds an unconsumed value
- out_ack  input  1  consumer has taken the current value; honoured only when out_valid=1
- busy  output  1  state != IDLE

## Operation
- States:
  - IDLE: no write in flight, out_valid=0.
  - WRITE: write_data=1, gnt pulse.
  - FULL: out_valid=1, waiting for out_ack.
- IDLE, any req bit set: the winner k is picked round-robin and the block moves to WRITE. data_to_write <= req_data[k], write_data <= 1, gnt[k] <= 1. All three are registered together.
- WRITE always moves to FULL after one cycle. In FULL: write_data=0, gnt=0, out_valid=1.
- FULL, out_ack=0: stay in FULL. Requests are not granted, which is the backpressure.
- FULL, out_ack=1, no req: move to IDLE with out_valid=0.
- FULL, out_ack=1, req pending: move straight to WRITE with a new winner. out_valid is cleared in that same edge and reasserted on the following edge.
- Round-robin pointer:
  - Reset value is 0, so req[0] has highest priority after reset.
  - After granting k, the priority order is k+1, k+2, …, wrapping modulo NREQ, and k is last.
  - The pointer updates only on a grant.
- A requester must drop req[i] in the cycle after it sees gnt[i]. If req[i] stays high, it is treated as a new request at lowest priority.
- out_ack is ignored in IDLE and WRITE.
- req_data of non-granted requesters is never sampled.

## Timing
- Reset asserted (reset=0) forces, asynchronously:
  - state IDLE, pointer 0
  - write_data=0, gnt=0, data_to_write=0, out_valid=0, busy=0
- If reset is asserted during WRITE, the write pulse is truncated. No grant is considered delivered and output_reg sees whatever its own reset produces.
- Latency from req sampled high in IDLE to write_data=1 is 1 clock edge.
- From write_data=1 to out_valid=1 is 1 clock edge.
- Throughput:
  - Minimum 2 cycles per write when out_ack is tied high and requests are continuously pending (WRITE, FULL, WRITE, …).
  - 3 cycles per write if a request arrives only after the return to IDLE.
- write_data is never high for 2 consecutive cycles.
- gnt is high in exactly the same cycle as write_data.
- data_to_write changes only on the edge entering WRITE. It is stable at least through the FULL cycle, so output_reg can capture it on either edge.
- Simultaneous requests in IDLE: exactly one grant, chosen by the pointer. The others wait with no starvation; each waits at most NREQ-1 grants.
- A request and out_ack arriving in the same FULL cycle resolve as a back-to-back write. No cycle is lost and no double-write occurs.

## Test plan
- Reset: assert reset=0 mid-cycle with all req=1 → all outputs 0 immediately. After reset=1, the first grant goes to req[0] with gnt=4'b0001 and data_to_write = req_data[0].
- Single request: req[2]=1 with data 0x5555…55 (256 bits), out_ack tied 1 → one write_data pulse, gnt=4'b0100, data_to_write=0x5555…55, out_valid=1 for one cycle, then IDLE.
- Fairness: req=4'b1111 held, out_ack=1 → grant order 0,1,2,3,0 with write pulses exactly 2 cycles apart.
- Backpressure: grant req[1] (0xAAAA…AA), hold out_ack=0 for 10 cycles while req[3]=1 → no second write_data and out_valid stays 1. Pulse out_ack → req[3] is written on the next edge.
- Same-cycle ack and request: in FULL, assert out_ack and a new req[0] together → write_data=1 on the very next edge, with out_valid low for exactly that one cycle.
- Reset mid-write: reset=0 during WRITE → write_data drops asynchronously. After release, the pointer is back at 0 and the pending requests are re-arbitrated from req[0].

Source files
------------

// File: rtl/output_reg_arbiter.sv
// ---------------------------------------------------------------------------
// output_reg_arbiter
//
// Round-robin arbiter and write sequencer that owns the write port of the
// 256-bit output register. One requester is granted at a time. The winner's
// data is registered onto data_to_write together with a one-cycle write_data
// strobe and a one-hot gnt pulse. Further writes are then held off until the
// downstream consumer acknowledges the value with out_ack.
//
// Ports:
//   clk           system clock, all state on the rising edge
//   reset         asynchronous, active-low; clears all state immediately
//   req           per-requester level request, held until granted
//   req_data      requester i data in bits [i*WIDTH +: WIDTH]
//   gnt           one-hot grant pulse, high in the same cycle as write_data
//   write_data    one-cycle write strobe to output_reg
//   data_to_write registered write data; holds the last written value
//   out_valid     output register holds an unconsumed value
//   out_ack       consumer took the current value (used only in FULL)
//   busy          sequencer is not idle
// ---------------------------------------------------------------------------
module output_reg_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    output logic                  write_data,
    output logic [WIDTH-1:0]      data_to_write,
    output logic                  out_valid,
    input  logic                  out_ack,
    output logic                  busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  ptr;        // index holding highest priority
    logic [IDX_W-1:0]  winner;
    logic              grant;
    logic [NREQ-1:0]   gnt_nxt;
    logic [WIDTH-1:0]  win_data;

    // Pick the requester closest to ptr going upwards (modulo NREQ).
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NREQ-1:0]  r,
        input logic [IDX_W-1:0] p
    );
        logic [IDX_W-1:0] w;
        int               best;
        int               off;
        w    = '0;
        best = NREQ;
        for (int j = 0; j < NREQ; j++) begin
            off = (j + NREQ - int'(p)) % NREQ;
            if (r[j] && (off < best)) begin
                best = off;
                w    = IDX_W'(j);
            end
        end
        return w;
    endfunction

    // After granting k, k+1 becomes the highest priority and k the lowest.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] k);
        return IDX_W'((int'(k) + 1) % NREQ);
    endfunction

    assign winner = rr_pick(req, ptr);

    // Only the granted requester's data is ever routed to the register.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (i == int'(winner)) begin
                win_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    grant     = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                state_nxt = FULL;
            end
            FULL: begin
                // A request and an ack in the same cycle chain straight into
                // the next write, so no cycle is lost between values.
                if (out_ack) begin
                    if (|req) begin
                        grant     = 1'b1;
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        gnt_nxt = '0;
        if (grant) begin
            gnt_nxt[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            ptr           <= '0;
            gnt           <= '0;
            data_to_write <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            if (grant) begin
                ptr           <= rr_next(winner);
                data_to_write <= win_data;
            end
        end
    end

    // Strobes decode directly from the state flops, so an asynchronous reset
    // truncates a write pulse immediately.
    assign write_data = (state == WRITE);
    assign out_valid  = (state == FULL);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_output_reg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_output_reg_arbiter
//
// Bench for output_reg_arbiter (NREQ=4, WIDTH=256): a directed vector table
// stepping through single-request, fairness, backpressure and same-cycle
// ack/request behaviour; hand-written reset sequences; then a randomized run
// compared against a transaction-level model of the arbiter.
// ---------------------------------------------------------------------------
module tb_output_reg_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 256;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic                  write_data;
    logic [WIDTH-1:0]      data_to_write;
    logic                  out_valid;
    logic                  out_ack;
    logic                  busy;

    logic [WIDTH-1:0]      rdata [NREQ];

    int errors;
    int checks;

    assign req_data = {rdata[3], rdata[2], rdata[1], rdata[0]};

    output_reg_arbiter #(
        .NREQ (NREQ),
        .WIDTH(WIDTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .gnt          (gnt),
        .write_data   (write_data),
        .data_to_write(data_to_write),
        .out_valid    (out_valid),
        .out_ack      (out_ack),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand256();
        logic [WIDTH-1:0] r;
        for (int k = 0; k < WIDTH / 32; k++) begin
            r[k*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

    // Directed vector table: inputs held across one rising edge, outputs
    // expected just after that edge.
    typedef struct {
        logic [NREQ-1:0] req;
        logic            ack;
        logic [NREQ-1:0] gnt;
        logic            wd;
        logic            valid;
        logic            busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] r, input logic a,
                                input logic [3:0] g, input logic w,
                                input logic v, input logic b);
        vec_t t;
        t.req   = r;
        t.ack   = a;
        t.gnt   = g;
        t.wd    = w;
        t.valid = v;
        t.busy  = b;
        return t;
    endfunction

    // Transaction-level reference: a value is either being written, sitting
    // unconsumed, or absent. A new write is accepted only when nothing is
    // outstanding or the outstanding value is acknowledged this cycle.
    int               m_first;   // requester with top priority
    bit               m_wd;
    bit               m_valid;
    logic [NREQ-1:0]  m_gnt;
    logic [WIDTH-1:0] m_data;
    int               waits [NREQ];

    task automatic model_reset();
        m_first = 0;
        m_wd    = 0;
        m_valid = 0;
        m_gnt   = '0;
        m_data  = '0;
        for (int i = 0; i < NREQ; i++) waits[i] = 0;
    endtask

    task automatic model_step(input logic [NREQ-1:0] r, input logic a);
        bit accept;
        int w;
        accept = (!m_wd && !m_valid) || (m_valid && a);
        if (accept && (r != '0)) begin
            w = -1;
            for (int j = 0; j < NREQ; j++) begin
                if (w < 0 && r[(m_first + j) % NREQ]) w = (m_first + j) % NREQ;
            end
            m_wd       = 1;
            m_valid    = 0;
            m_gnt      = '0;
            m_gnt[w]   = 1'b1;
            m_data     = rdata[w];
            m_first    = (w + 1) % NREQ;
        end else if (m_wd) begin
            m_wd    = 0;
            m_gnt   = '0;
            m_valid = 1;
        end else begin
            m_gnt = '0;
            if (m_valid && a) m_valid = 0;
        end
    endtask

    logic [WIDTH-1:0] exp_data;
    vec_t             v;

    initial begin
        errors   = 0;
        checks   = 0;
        reset    = 1'b0;
        req      = '0;
        out_ack  = 1'b0;
        rdata[0] = {32{8'h11}};
        rdata[1] = {32{8'hAA}};
        rdata[2] = {32{8'h55}};
        rdata[3] = {32{8'hCC}};

        // Single request, then fairness with all four held, then
        // backpressure, then same-cycle ack and request.
        tbl.push_back(mk(4'b0100, 1, 4'b0100, 1, 0, 1));
        tbl.push_back(mk(4'b0000, 1, 4'b0000, 0, 1, 1));
        tbl.push_back(mk(4'b0000, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(4'b1111, 1, 4'b1000, 1, 0, 1));
        tbl.push_back(mk(4'b1111, 1, 4'b0000, 0, 1, 1));
        tbl.push_back(mk(4'b1111, 1, 4'b0001, 1, 0, 1));
        tbl.push_back(mk(4'b1111, 1, 4'b0000, 0, 1, 1));
        tbl.push_back(mk(4'b1111, 1, 4'b0010, 1, 0, 1));
        tbl.push_back(mk(4'b1111, 1, 4'b0000, 0, 1, 1));
        tbl.push_back(mk(4'b1111, 1, 4'b0100, 1, 0, 1));
        tbl.push_back(mk(4'b1111, 1, 4'b0000, 0, 1, 1));
        tbl.push_back(mk(4'b1111, 1, 4'b1000, 1, 0, 1));
        for (int i = 0; i < 10; i++) begin
            tbl.push_back(mk(4'b1010, 0, 4'b0000, 0, 1, 1));
        end
        tbl.push_back(mk(4'b1010, 1, 4'b0010, 1, 0, 1));
        tbl.push_back(mk(4'b1000, 0, 4'b0000, 0, 1, 1));
        tbl.push_back(mk(4'b1000, 0, 4'b0000, 0, 1, 1));
        tbl.push_back(mk(4'b1000, 1, 4'b1000, 1, 0, 1));
        tbl.push_back(mk(4'b0000, 0, 4'b0000, 0, 1, 1));
        tbl.push_back(mk(4'b0000, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 1, 4'b0000, 0, 0, 0));

        repeat (2) @(negedge clk);
        chk("rst_gnt",   gnt,           '0);
        chk("rst_wd",    write_data,    '0);
        chk("rst_data",  data_to_write, '0);
        chk("rst_valid", out_valid,     '0);
        chk("rst_busy",  busy,          '0);
        reset    = 1'b1;
        exp_data = '0;

        // Directed table
        for (int n = 0; n < tbl.size(); n++) begin
            v = tbl[n];
            if (n != 0) @(negedge clk);
            req     = v.req;
            out_ack = v.ack;
            @(posedge clk);
            #1;
            if (v.wd) exp_data = rdata[onehot_idx(v.gnt)];
            chk($sformatf("vec%0d_gnt", n),   gnt,           v.gnt);
            chk($sformatf("vec%0d_wd", n),    write_data,    v.wd);
            chk($sformatf("vec%0d_valid", n), out_valid,     v.valid);
            chk($sformatf("vec%0d_busy", n),  busy,          v.busy);
            chk($sformatf("vec%0d_data", n),  data_to_write, exp_data);
        end

        // Asynchronous reset with every requester active, mid-cycle
        @(negedge clk);
        req     = 4'b1111;
        out_ack = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_gnt",   gnt,           '0);
        chk("arst_wd",    write_data,    '0);
        chk("arst_data",  data_to_write, '0);
        chk("arst_valid", out_valid,     '0);
        chk("arst_busy",  busy,          '0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_gnt",  gnt,           4'b0001);
        chk("post_rst_wd",   write_data,    1'b1);
        chk("post_rst_data", data_to_write, rdata[0]);

        // Reset during WRITE: pulse truncated, pointer back to 0
        @(negedge clk);
        req = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        req = 4'b1110;
        @(posedge clk);
        #1;
        chk("mw_pre_gnt", gnt,        4'b0010);
        chk("mw_pre_wd",  write_data, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("mw_wd",   write_data, 1'b0);
        chk("mw_gnt",  gnt,        '0);
        chk("mw_busy", busy,       1'b0);
        @(negedge clk);
        req   = 4'b1111;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mw_rearb_gnt",  gnt,           4'b0001);
        chk("mw_rearb_data", data_to_write, rdata[0]);

        // Randomized run against the reference model
        @(negedge clk);
        reset   = 1'b0;
        req     = '0;
        out_ack = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (m_gnt[i]) begin
                    if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    rdata[i] = rand256();
                    req[i]   = 1'b1;
                end
            end
            out_ack = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            model_step(req, out_ack);
            #1;
            chk($sformatf("rnd%0d_gnt", c),   gnt,           m_gnt);
            chk($sformatf("rnd%0d_wd", c),    write_data,    m_wd);
            chk($sformatf("rnd%0d_valid", c), out_valid,     m_valid);
            chk($sformatf("rnd%0d_busy", c),  busy,          m_wd | m_valid);
            chk($sformatf("rnd%0d_data", c),  data_to_write, m_data);
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i]) begin
                    chk($sformatf("rnd%0d_starve%0d", c, i), waits[i] > NREQ - 1, 1'b0);
                    waits[i] = 0;
                end else if (gnt != '0 && req[i]) begin
                    waits[i]++;
                end
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
